// File: rtl/stitch_line_arbiter_pkg.sv
// Shared types and defaults for the stitch line arbiter: FSM encoding,
// mux select constants and default geometry.
package stitch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_e;

    localparam logic SEL_LEFT  = 1'b0;
    localparam logic SEL_RIGHT = 1'b1;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_LINE_LEN    = 1024;
    localparam int unsigned DEF_FRAME_LINES = 720;

endpackage

// File: rtl/stitch_line_arbiter_if.sv
// Bundle of the two FWFT FIFO read ports and the stitched output stream.
// The arbiter uses the master modport; the FIFO/downstream side uses slave.
interface stitch_line_arbiter_if #(
    parameter int DATA_WIDTH = stitch_pkg::DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] l_rdata_i;
    logic                  l_rd_valid_i;
    logic                  l_line_rdy_i;
    logic                  l_rd_en_o;
    logic [DATA_WIDTH-1:0] r_rdata_i;
    logic                  r_rd_valid_i;
    logic                  r_line_rdy_i;
    logic                  r_rd_en_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic                  out_sol_o;
    logic                  out_eol_o;
    logic                  out_eof_o;

    modport master (
        input  l_rdata_i, l_rd_valid_i, l_line_rdy_i,
        input  r_rdata_i, r_rd_valid_i, r_line_rdy_i,
        input  out_ready_i,
        output l_rd_en_o, r_rd_en_o,
        output out_data_o, out_valid_o, out_sol_o, out_eol_o, out_eof_o
    );

    modport slave (
        output l_rdata_i, l_rd_valid_i, l_line_rdy_i,
        output r_rdata_i, r_rd_valid_i, r_line_rdy_i,
        output out_ready_i,
        input  l_rd_en_o, r_rd_en_o,
        input  out_data_o, out_valid_o, out_sol_o, out_eol_o, out_eof_o
    );
endinterface

// File: rtl/stitch_beat_counter.sv
// Beat counter within a half-line and line counter within a frame,
// exposing the terminal-count flags the arbiter FSM decodes.
module stitch_beat_counter #(
    parameter int LINE_LEN    = 1024,
    parameter int FRAME_LINES = 720
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_i,
    input  logic line_beat_i,
    output logic beat_zero_o,
    output logic beat_last_o,
    output logic line_last_o
);
    localparam int CNT_W  = $clog2(LINE_LEN + 1);
    localparam int LCNT_W = $clog2(FRAME_LINES + 1);

    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;

    assign beat_zero_o = (beat_cnt_q == '0);
    assign beat_last_o = (beat_cnt_q == CNT_W'(LINE_LEN - 1));
    assign line_last_o = (line_cnt_q == LCNT_W'(FRAME_LINES - 1));

    // Wrapping on the last beat covers both the LEFT->RIGHT and RIGHT->WAIT clears.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        line_cnt_d = line_cnt_q;
        if (beat_i) begin
            beat_cnt_d = beat_last_o ? '0 : beat_cnt_q + CNT_W'(1);
        end
        if (line_beat_i) begin
            line_cnt_d = line_last_o ? '0 : line_cnt_q + LCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            line_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end
endmodule

// File: rtl/stitch_line_arbiter.sv
// Drains LINE_LEN words from the left FIFO then LINE_LEN from the right per
// stitched line. Optional stall counter enabled by STITCH_PERF_CNT_EN.
module stitch_line_arbiter
    import stitch_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LINE_LEN    = DEF_LINE_LEN,
    parameter int FRAME_LINES = DEF_FRAME_LINES
) (
    input  logic                     rd_clk_i,
    input  logic                     sys_rst_n,
    input  logic                     enable_i,
    stitch_line_arbiter_if.master    bus,
    output logic                     busy_o,
    output logic                     underrun_o
`ifdef STITCH_PERF_CNT_EN
    ,
    input  logic                     clr_perf_i,
    output logic [31:0]              stall_cnt_o
`endif
);
    state_e state_q, state_d;
    logic   underrun_q, underrun_d;
    logic   active, sel, sel_valid, accept, eol, line_beat;
    logic   beat_zero, beat_last, line_last;
    logic [DATA_WIDTH-1:0] sel_data;

    stitch_beat_counter #(
        .LINE_LEN   (LINE_LEN),
        .FRAME_LINES(FRAME_LINES)
    ) u_cnt (
        .clk        (rd_clk_i),
        .rst_n      (sys_rst_n),
        .beat_i     (accept),
        .line_beat_i(line_beat),
        .beat_zero_o(beat_zero),
        .beat_last_o(beat_last),
        .line_last_o(line_last)
    );

    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            underrun_q <= underrun_d;
        end
    end

    // enable_i only matters in IDLE/WAIT and at frame end; a started line always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable_i) state_d = ST_WAIT;
            ST_WAIT: begin
                if (!enable_i)                                state_d = ST_IDLE;
                else if (bus.l_line_rdy_i && bus.r_line_rdy_i) state_d = ST_LEFT;
            end
            ST_LEFT:  if (accept && beat_last) state_d = ST_RIGHT;
            ST_RIGHT: begin
                if (accept && beat_last)
                    state_d = (line_last && !enable_i) ? ST_IDLE : ST_WAIT;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Zero-latency mux; the data bus is forced to 0 outside LEFT/RIGHT so reset blanks it.
    always_comb begin
        active    = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
        sel       = (state_q == ST_RIGHT) ? SEL_RIGHT : SEL_LEFT;
        sel_valid = (sel == SEL_RIGHT) ? bus.r_rd_valid_i : bus.l_rd_valid_i;
        sel_data  = (sel == SEL_RIGHT) ? bus.r_rdata_i : bus.l_rdata_i;
        accept    = active && sel_valid && bus.out_ready_i;
        eol       = (state_q == ST_RIGHT) && beat_last;
        line_beat = accept && eol;

        bus.out_data_o  = active ? sel_data : '0;
        bus.out_valid_o = active && sel_valid;
        bus.l_rd_en_o   = accept && (sel == SEL_LEFT);
        bus.r_rd_en_o   = accept && (sel == SEL_RIGHT);
        bus.out_sol_o   = (state_q == ST_LEFT) && beat_zero;
        bus.out_eol_o   = eol;
        bus.out_eof_o   = eol && line_last;
        busy_o          = (state_q != ST_IDLE);
        underrun_o      = underrun_q;
        underrun_d      = underrun_q || (active && !sel_valid);
    end

`ifdef STITCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_perf_i)
            stall_cnt_d = '0;
        else if (active && bus.out_ready_i && !accept && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) stall_cnt_q <= '0;
        else            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stitch_line_arbiter.sv
// Directed bench for stitch_line_arbiter with LINE_LEN=4, FRAME_LINES=2 and
// simple FWFT FIFO models on both sides.
module tb_stitch_line_arbiter;
    localparam int DW = 16;
    localparam int LL = 4;
    localparam int FL = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic ready  = 1'b1;
    logic l_hold = 1'b0;
    logic r_hold = 1'b0;
    logic busy, underrun;
`ifdef STITCH_PERF_CNT_EN
    logic        clr_perf = 1'b0;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] lmem [64];
    logic [15:0] rmem [64];
    logic [6:0]  lwr = '0, lrd = '0, rwr = '0, rrd = '0;
    logic [6:0]  l_cnt, r_cnt;

    stitch_line_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    stitch_line_arbiter #(
        .DATA_WIDTH (DW),
        .LINE_LEN   (LL),
        .FRAME_LINES(FL)
    ) dut (
        .rd_clk_i  (clk),
        .sys_rst_n (rst_n),
        .enable_i  (enable),
        .bus       (bus),
        .busy_o    (busy),
        .underrun_o(underrun)
`ifdef STITCH_PERF_CNT_EN
        ,
        .clr_perf_i (clr_perf),
        .stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign l_cnt = lwr - lrd;
    assign r_cnt = rwr - rrd;
    assign bus.l_rdata_i    = lmem[lrd[5:0]];
    assign bus.l_rd_valid_i = (l_cnt != 7'd0) && !l_hold;
    assign bus.l_line_rdy_i = (l_cnt >= 7'd4);
    assign bus.r_rdata_i    = rmem[rrd[5:0]];
    assign bus.r_rd_valid_i = (r_cnt != 7'd0) && !r_hold;
    assign bus.r_line_rdy_i = (r_cnt >= 7'd4);
    assign bus.out_ready_i  = ready;

    always @(posedge clk) begin
        if (bus.l_rd_en_o) lrd <= lrd + 7'd1;
        if (bus.r_rd_en_o) rrd <= rrd + 7'd1;
    end

    logic        s_valid, s_acc, s_sol, s_eol, s_eof, s_len, s_ren, s_busy, s_under;
    logic [15:0] s_data;

    task automatic sample();
        #1;
        s_valid = bus.out_valid_o;
        s_acc   = bus.out_valid_o & ready;
        s_data  = bus.out_data_o;
        s_sol   = bus.out_sol_o;
        s_eol   = bus.out_eol_o;
        s_eof   = bus.out_eof_o;
        s_len   = bus.l_rd_en_o;
        s_ren   = bus.r_rd_en_o;
        s_busy  = busy;
        s_under = underrun;
    endtask

    task automatic push_left(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            lmem[lwr[5:0]] = base + 16'(i);
            lwr = lwr + 7'd1;
        end
    endtask

    task automatic push_right(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            rmem[rwr[5:0]] = base + 16'(i);
            rwr = rwr + 7'd1;
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] lb, input logic [15:0] rb, input int nb);
        return (nb < 4) ? lb + 16'(nb) : rb + 16'(nb - 4);
    endfunction

    task automatic test_reset();
        push_left(16'h0001);
        push_right(16'h0101);
        enable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sample();
            n_checks++;
            if (s_valid !== 1'b0 || s_data !== 16'h0000 || s_len !== 1'b0 || s_ren !== 1'b0 ||
                s_busy !== 1'b0 || s_under !== 1'b0 || s_sol !== 1'b0 || s_eol !== 1'b0 || s_eof !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%b data=%h len=%b ren=%b busy=%b under=%b sol=%b eol=%b eof=%b, expected all 0",
                         s_valid, s_data, s_len, s_ren, s_busy, s_under, s_sol, s_eol, s_eof);
            end
        end
`ifdef STITCH_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_first_line();
        int nb = 0, cyc = 0, first = 0, lcnt = 0, rcnt = 0;
        logic [15:0] exp;
        while (nb < 8 && cyc < 40) begin
            @(negedge clk);
            sample();
            cyc++;
            if (s_len) lcnt++;
            if (s_ren) rcnt++;
            if (s_acc) begin
                exp = exp_word(16'h0001, 16'h0101, nb);
                n_checks++;
                if (s_data !== exp || s_sol !== (nb == 0) || s_eol !== (nb == 7) || s_eof !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_line beat %0d: got data=%h sol=%b eol=%b eof=%b, expected data=%h sol=%b eol=%b eof=0",
                             nb, s_data, s_sol, s_eol, s_eof, exp, nb == 0, nb == 7);
                end
                if (nb == 0) first = cyc;
                nb++;
            end
        end
        n_checks++;
        if (nb != 8 || (cyc - first) != 7) begin
            n_fail++;
            $display("FAIL first_line_beats: got %0d beats over %0d cycles, expected 8 over 8", nb, cyc - first + 1);
        end
        n_checks++;
        if (lcnt != 4 || rcnt != 4) begin
            n_fail++;
            $display("FAIL first_line_pops: got l_rd_en=%0d r_rd_en=%0d, expected 4 and 4", lcnt, rcnt);
        end
        @(negedge clk);
        sample();
        n_checks++;
        if (s_busy !== 1'b1 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_line_wait: got busy=%b valid=%b, expected busy=1 valid=0", s_busy, s_valid);
        end
        $display("first line: %0d beats", nb);
    endtask

    task automatic test_eof_line();
        int nb = 0, cyc = 0;
        logic [15:0] exp;
        push_left(16'h0011);
        push_right(16'h0111);
        while (nb < 8 && cyc < 40) begin
            @(negedge clk);
            sample();
            cyc++;
            if (s_acc) begin
                exp = exp_word(16'h0011, 16'h0111, nb);
                n_checks++;
                if (s_data !== exp || s_eol !== (nb == 7) || s_eof !== (nb == 7)) begin
                    n_fail++;
                    $display("FAIL eof_line beat %0d: got data=%h eol=%b eof=%b, expected data=%h eol=%b eof=%b",
                             nb, s_data, s_eol, s_eof, exp, nb == 7, nb == 7);
                end
                if (nb == 0) enable = 1'b0;
                nb++;
            end
        end
        n_checks++;
        if (nb != 8) begin
            n_fail++;
            $display("FAIL eof_line_beats: got %0d expected 8", nb);
        end
        @(negedge clk);
        sample();
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL eof_line_idle: got busy=%b expected 0", s_busy);
        end
        $display("eof line: %0d beats, returned to idle", nb);
    endtask

    task automatic test_stall_ready();
        int nb = 0, cyc = 0, vidx = 0, stalls = 0, lcnt = 0;
        logic [15:0] exp;
        enable = 1'b1;
        push_left(16'h0021);
        push_right(16'h0121);
        while (nb < 8 && cyc < 40) begin
            @(negedge clk);
            #1;
            if (bus.out_valid_o) begin
                ready = !(vidx == 1 || vidx == 2);
                vidx++;
            end else begin
                ready = 1'b1;
            end
            sample();
            cyc++;
            if (s_len) lcnt++;
            if (s_valid && !ready) begin
                stalls++;
                n_checks++;
                if (s_len !== 1'b0 || s_data !== 16'h0022) begin
                    n_fail++;
                    $display("FAIL stall_hold: got len=%b data=%h, expected len=0 data=0022", s_len, s_data);
                end
            end
            if (s_acc) begin
                exp = exp_word(16'h0021, 16'h0121, nb);
                n_checks++;
                if (s_data !== exp || s_eol !== (nb == 7) || s_eof !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_line beat %0d: got data=%h eol=%b eof=%b, expected data=%h eol=%b eof=0",
                             nb, s_data, s_eol, s_eof, exp, nb == 7);
                end
                nb++;
            end
        end
        ready = 1'b1;
        n_checks++;
        if (nb != 8 || stalls != 2 || lcnt != 4) begin
            n_fail++;
            $display("FAIL stall_counts: got beats=%0d stalls=%0d l_pops=%0d, expected 8 2 4", nb, stalls, lcnt);
        end
`ifdef STITCH_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_perf: got %0d expected 0", stall_cnt);
        end
`endif
        $display("ready stall line: %0d beats, %0d stall cycles", nb, stalls);
    endtask

    task automatic test_wait_one_side();
        int nb = 1, cyc = 0;
        logic [15:0] exp;
        push_left(16'h0031);
        repeat (5) begin
            @(negedge clk);
            sample();
            n_checks++;
            if (s_valid !== 1'b0 || s_len !== 1'b0 || s_ren !== 1'b0 || s_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL one_side_wait: got valid=%b len=%b ren=%b busy=%b, expected 0 0 0 1",
                         s_valid, s_len, s_ren, s_busy);
            end
        end
        @(negedge clk);
        push_right(16'h0131);
        sample();
        n_checks++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL one_side_rise: got valid=%b expected 0", s_valid);
        end
        @(negedge clk);
        sample();
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== 16'h0031 || s_sol !== 1'b1 || s_len !== 1'b1) begin
            n_fail++;
            $display("FAIL one_side_start: got valid=%b data=%h sol=%b len=%b, expected 1 0031 1 1",
                     s_valid, s_data, s_sol, s_len);
        end
        while (nb < 8 && cyc < 40) begin
            @(negedge clk);
            sample();
            cyc++;
            if (s_acc) begin
                exp = exp_word(16'h0031, 16'h0131, nb);
                n_checks++;
                if (s_data !== exp || s_eof !== (nb == 7)) begin
                    n_fail++;
                    $display("FAIL one_side_line beat %0d: got data=%h eof=%b, expected data=%h eof=%b",
                             nb, s_data, s_eof, exp, nb == 7);
                end
                nb++;
            end
        end
        n_checks++;
        if (nb != 8) begin
            n_fail++;
            $display("FAIL one_side_beats: got %0d expected 8", nb);
        end
        $display("one-sided wait then line: %0d beats", nb);
    endtask

    task automatic test_underrun();
        int nb = 0, cyc = 0, rbeats = 0, hd = 0;
        logic [15:0] exp;
`ifdef STITCH_PERF_CNT_EN
        @(negedge clk);
        clr_perf = 1'b1;
        @(negedge clk);
        clr_perf = 1'b0;
`endif
        push_left(16'h0041);
        push_right(16'h0141);
        while (nb < 8 && cyc < 40) begin
            @(negedge clk);
            if (rbeats == 1 && hd < 3) begin
                r_hold = 1'b1;
                hd++;
            end else begin
                r_hold = 1'b0;
            end
            sample();
            cyc++;
            if (cyc == 1) begin
                n_checks++;
                if (s_under !== 1'b0) begin
                    n_fail++;
                    $display("FAIL underrun_initial: got %b expected 0", s_under);
                end
            end
            if (r_hold) begin
                n_checks++;
                if (s_ren !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL underrun_hold: got ren=%b valid=%b busy=%b, expected 0 0 1", s_ren, s_valid, s_busy);
                end
            end
            if (s_acc) begin
                exp = exp_word(16'h0041, 16'h0141, nb);
                n_checks++;
                if (s_data !== exp) begin
                    n_fail++;
                    $display("FAIL underrun_line beat %0d: got data=%h expected %h", nb, s_data, exp);
                end
                if (nb >= 4) rbeats++;
                nb++;
            end
        end
        r_hold = 1'b0;
        n_checks++;
        if (nb != 8 || hd != 3) begin
            n_fail++;
            $display("FAIL underrun_beats: got beats=%0d holds=%0d, expected 8 3", nb, hd);
        end
        @(negedge clk);
        sample();
        n_checks++;
        if (s_under !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_sticky: got %b expected 1", s_under);
        end
`ifdef STITCH_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL underrun_perf: got %0d expected 3", stall_cnt);
        end
`endif
        $display("underrun line: %0d beats, %0d invalid cycles", nb, hd);
    endtask

    task automatic test_reset_mid_right();
        int nb = 0, cyc = 0, rbeats = 0;
        logic [15:0] exp_tbl [8];
        exp_tbl = '{16'h0061, 16'h0062, 16'h0063, 16'h0064, 16'h0153, 16'h0154, 16'h0161, 16'h0162};
        push_left(16'h0051);
        push_right(16'h0151);
        while (rbeats < 2 && cyc < 40) begin
            @(negedge clk);
            sample();
            cyc++;
            if (s_acc && s_ren) rbeats++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 16'h0153) begin
            n_fail++;
            $display("FAIL pre_reset_right: got valid=%b data=%h, expected 1 0153", bus.out_valid_o, bus.out_data_o);
        end
        rst_n = 1'b0;
        sample();
        n_checks++;
        if (s_valid !== 1'b0 || s_data !== 16'h0000 || s_len !== 1'b0 || s_ren !== 1'b0 || s_busy !== 1'b0 ||
            s_under !== 1'b0 || s_sol !== 1'b0 || s_eol !== 1'b0 || s_eof !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got valid=%b data=%h len=%b ren=%b busy=%b under=%b sol=%b eol=%b eof=%b, expected all 0",
                     s_valid, s_data, s_len, s_ren, s_busy, s_under, s_sol, s_eol, s_eof);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_left(16'h0061);
        push_right(16'h0161);
        sample();
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b expected 0", s_busy);
        end
        cyc = 0;
        while (nb < 8 && cyc < 40) begin
            @(negedge clk);
            sample();
            cyc++;
            if (s_acc) begin
                n_checks++;
                if (s_data !== exp_tbl[nb] || s_sol !== (nb == 0) || s_len !== (nb < 4) ||
                    s_eol !== (nb == 7) || s_eof !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_reset_line beat %0d: got data=%h sol=%b len=%b eol=%b eof=%b, expected data=%h sol=%b len=%b eol=%b eof=0",
                             nb, s_data, s_sol, s_len, s_eol, s_eof, exp_tbl[nb], nb == 0, nb < 4, nb == 7);
                end
                nb++;
            end
        end
        n_checks++;
        if (nb != 8) begin
            n_fail++;
            $display("FAIL post_reset_beats: got %0d expected 8", nb);
        end
        $display("reset mid-right then new line: %0d beats", nb);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            lmem[i] = 16'h0000;
            rmem[i] = 16'h0000;
        end
        test_reset();
        test_first_line();
        test_eof_line();
        test_stall_ready();
        test_wait_one_side();
        test_underrun();
        test_reset_mid_right();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
